// File: rtl/stopwatch_pkg.sv
// Timebase constants shared by the stopwatch blocks: board oscillator and tick rate.
package stopwatch_pkg;
   localparam int CLK_IN_HZ_DEFAULT = 50000000;
   localparam int TICK_HZ           = 100;
endpackage

// File: rtl/mod_n_counter.sv
// Free-running modulo-N counter with a wrap flag that is high while the count sits at N-1.
module mod_n_counter #(
   parameter int N = 10,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   // Using >= instead of == pulls any upset out-of-range value back to zero.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (cnt >= W'(N - 1))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign wrap = (cnt == W'(N - 1));

endmodule

// File: rtl/clock_divider_50mhz_to_100hz.sv
// Divides the board clock to a registered 50%-duty square wave (100 Hz by default).
module clock_divider_50mhz_to_100hz
   import stopwatch_pkg::*;
#(
   parameter int CLK_IN_HZ  = CLK_IN_HZ_DEFAULT,
   parameter int CLK_OUT_HZ = TICK_HZ,
   parameter int DIVISOR    = CLK_IN_HZ / CLK_OUT_HZ,
   parameter int HALF       = DIVISOR / 2,
   parameter int CNT_W      = $clog2(DIVISOR)
) (
   input  logic CLK_50_MHz,
   input  logic reset,
   output logic CLK_100Hz
);

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             half;

   mod_n_counter #(
      .N (DIVISOR),
      .W (CNT_W)
   ) u_counter (
      .clk   (CLK_50_MHz),
      .reset (reset),
      .cnt   (cnt),
      .wrap  (wrap)
   );

   assign half = (cnt == CNT_W'(HALF - 1));

   // Output toggles straight from a flop so downstream sees no decode glitches.
   always_ff @(posedge CLK_50_MHz) begin
      if (reset)
         CLK_100Hz <= 1'b0;
      else if (half || wrap)
         CLK_100Hz <= ~CLK_100Hz;
   end

endmodule

// File: tb/tb_clock_divider_50mhz_to_100hz.sv
// Directed bench: default divider for reset/counting, scaled dividers (1000 and 10) for full-period timing.
module tb_clock_divider_50mhz_to_100hz;

   logic clk;
   logic reset;
   logic out_def;
   logic out_mid;
   logic out_small;

   int checks;
   int fails;

   clock_divider_50mhz_to_100hz dut_def (
      .CLK_50_MHz (clk),
      .reset      (reset),
      .CLK_100Hz  (out_def)
   );

   // 100 kHz in -> divisor 1000, half 500
   clock_divider_50mhz_to_100hz #(
      .CLK_IN_HZ  (100000),
      .CLK_OUT_HZ (100)
   ) dut_mid (
      .CLK_50_MHz (clk),
      .reset      (reset),
      .CLK_100Hz  (out_mid)
   );

   // 1 kHz in -> divisor 10, half 5
   clock_divider_50mhz_to_100hz #(
      .CLK_IN_HZ  (1000),
      .CLK_OUT_HZ (100)
   ) dut_small (
      .CLK_50_MHz (clk),
      .reset      (reset),
      .CLK_100Hz  (out_small)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int v;
      reset = 1'b1;
      tick();
      checks++;
      if (out_def !== 1'b0 || dut_def.cnt !== 18'd0) begin
         fails++;
         $display("FAIL reset_def: got out=%b cnt=%0d expected out=0 cnt=0", out_def, dut_def.cnt);
      end
      checks++;
      if (out_mid !== 1'b0 || dut_mid.cnt !== 10'd0) begin
         fails++;
         $display("FAIL reset_mid: got out=%b cnt=%0d expected out=0 cnt=0", out_mid, dut_mid.cnt);
      end
      checks++;
      if (out_small !== 1'b0 || dut_small.cnt !== 4'd0) begin
         fails++;
         $display("FAIL reset_small: got out=%b cnt=%0d expected out=0 cnt=0", out_small, dut_small.cnt);
      end
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         v = int'(dut_def.cnt);
         checks++;
         if (v !== i) begin
            fails++;
            $display("FAIL count_after_reset: edge %0d got cnt=%0d expected %0d", i, v, i);
         end
      end
      $display("test_reset done: checks=%0d fails=%0d", checks, fails);
   endtask

   // Default divider: count tracks edge number and output stays low well before 125000.
   task automatic test_default_run();
      int v;
      for (int n = 6; n <= 3000; n++) begin
         tick();
         v = int'(dut_def.cnt);
         checks++;
         if (v !== n || out_def !== 1'b0) begin
            fails++;
            $display("FAIL default_run: edge %0d got cnt=%0d out=%b expected cnt=%0d out=0", n, v, out_def, n);
            break;
         end
      end
      $display("test_default_run done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_phases();
      int v, exp_cnt, rise_n, fall_n;
      logic exp_out, prev;
      rise_n = -1;
      fall_n = -1;
      apply_reset(1);
      prev = out_mid;
      for (int n = 1; n <= 1200; n++) begin
         tick();
         exp_cnt = n % 1000;
         exp_out = (exp_cnt >= 500);
         v = int'(dut_mid.cnt);
         checks++;
         if (v !== exp_cnt || out_mid !== exp_out) begin
            fails++;
            $display("FAIL phase_model: edge %0d got cnt=%0d out=%b expected cnt=%0d out=%b", n, v, out_mid, exp_cnt, exp_out);
            break;
         end
         if (!prev && out_mid && rise_n < 0) rise_n = n;
         if (prev && !out_mid && fall_n < 0) fall_n = n;
         prev = out_mid;
      end
      checks++;
      if (rise_n !== 500) begin
         fails++;
         $display("FAIL first_rise: got edge %0d expected 500", rise_n);
      end
      checks++;
      if (fall_n !== 1000) begin
         fails++;
         $display("FAIL first_fall: got edge %0d expected 1000", fall_n);
      end
      checks++;
      if (fall_n - rise_n !== 500) begin
         fails++;
         $display("FAIL high_time: got %0d cycles expected 500", fall_n - rise_n);
      end
      $display("test_phases done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_multi_period();
      time rise_t[4];
      int  rises, falls, max_cnt;
      logic prev;
      rises = 0;
      falls = 0;
      max_cnt = 0;
      apply_reset(1);
      prev = out_mid;
      for (int n = 1; n <= 2400; n++) begin
         tick();
         if (int'(dut_mid.cnt) > max_cnt) max_cnt = int'(dut_mid.cnt);
         if (!prev && out_mid) begin
            if (rises < 4) rise_t[rises] = $time;
            rises++;
         end
         if (prev && !out_mid) falls++;
         prev = out_mid;
      end
      checks++;
      if (rises !== 2 || falls !== 2) begin
         fails++;
         $display("FAIL edge_count: got rises=%0d falls=%0d expected 2 and 2", rises, falls);
      end
      checks++;
      if (rises >= 2 && (rise_t[1] - rise_t[0]) !== 64'd20000) begin
         fails++;
         $display("FAIL period_ns: got %0t expected 20000", rise_t[1] - rise_t[0]);
      end
      checks++;
      if (max_cnt !== 999) begin
         fails++;
         $display("FAIL max_cnt: got %0d expected 999", max_cnt);
      end
      $display("test_multi_period done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_mid_reset();
      int wait_n;
      apply_reset(1);
      repeat (750) tick();
      checks++;
      if (out_mid !== 1'b1 || dut_mid.cnt !== 10'd750) begin
         fails++;
         $display("FAIL before_pulse: got out=%b cnt=%0d expected out=1 cnt=750", out_mid, dut_mid.cnt);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (out_mid !== 1'b0 || dut_mid.cnt !== 10'd0) begin
         fails++;
         $display("FAIL pulse_first_edge: got out=%b cnt=%0d expected out=0 cnt=0", out_mid, dut_mid.cnt);
      end
      repeat (4) tick();
      checks++;
      if (out_mid !== 1'b0 || dut_mid.cnt !== 10'd0) begin
         fails++;
         $display("FAIL pulse_held: got out=%b cnt=%0d expected out=0 cnt=0", out_mid, dut_mid.cnt);
      end
      reset = 1'b0;
      wait_n = 0;
      while (out_mid !== 1'b1 && wait_n < 2000) begin
         tick();
         wait_n++;
      end
      checks++;
      if (wait_n !== 500) begin
         fails++;
         $display("FAIL rise_after_pulse: got %0d edges expected 500", wait_n);
      end
      $display("test_mid_reset done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_reset_on_boundary();
      apply_reset(1);
      repeat (499) tick();
      checks++;
      if (dut_mid.cnt !== 10'd499 || out_mid !== 1'b0) begin
         fails++;
         $display("FAIL at_half_minus_1: got cnt=%0d out=%b expected cnt=499 out=0", dut_mid.cnt, out_mid);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (dut_mid.cnt !== 10'd0 || out_mid !== 1'b0) begin
         fails++;
         $display("FAIL reset_wins_half: got cnt=%0d out=%b expected cnt=0 out=0", dut_mid.cnt, out_mid);
      end
      reset = 1'b0;
      repeat (999) tick();
      checks++;
      if (dut_mid.cnt !== 10'd999 || out_mid !== 1'b1) begin
         fails++;
         $display("FAIL at_div_minus_1: got cnt=%0d out=%b expected cnt=999 out=1", dut_mid.cnt, out_mid);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (dut_mid.cnt !== 10'd0 || out_mid !== 1'b0) begin
         fails++;
         $display("FAIL reset_wins_wrap: got cnt=%0d out=%b expected cnt=0 out=0", dut_mid.cnt, out_mid);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (dut_mid.cnt !== 10'd1 || out_mid !== 1'b0) begin
         fails++;
         $display("FAIL restart_after_boundary: got cnt=%0d out=%b expected cnt=1 out=0", dut_mid.cnt, out_mid);
      end
      $display("test_reset_on_boundary done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_small_divisor();
      int v, exp_cnt, prev_cnt, wraps;
      logic exp_out;
      wraps = 0;
      apply_reset(1);
      prev_cnt = int'(dut_small.cnt);
      for (int n = 1; n <= 30; n++) begin
         tick();
         exp_cnt = n % 10;
         exp_out = (exp_cnt >= 5);
         v = int'(dut_small.cnt);
         checks++;
         if (v !== exp_cnt || out_small !== exp_out) begin
            fails++;
            $display("FAIL small_model: edge %0d got cnt=%0d out=%b expected cnt=%0d out=%b", n, v, out_small, exp_cnt, exp_out);
         end
         if (prev_cnt == 9 && v == 0) wraps++;
         prev_cnt = v;
      end
      checks++;
      if (wraps !== 3) begin
         fails++;
         $display("FAIL small_wraps: got %0d wraps expected 3", wraps);
      end
      $display("test_small_divisor done: checks=%0d fails=%0d", checks, fails);
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      reset  = 1'b1;
      test_reset();
      test_default_run();
      test_phases();
      test_multi_period();
      test_mid_reset();
      test_reset_on_boundary();
      test_small_divisor();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
